// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode 7-seg scanner with anti-ghost blanking, frame snapshot and 1 Hz DP blink.
// Optional DISP_LZ_BLANK_EN: blanks the minutes-tens digit when it is zero.
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic       clk_flag,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  typedef enum logic [1:0] {S_BLANK = 2'd0, S_DRIVE = 2'd1} state_t;
  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [15:0]   snapshot;
  logic          dp_phase;
  logic          wrap;
  logic          drive;
  logic [3:0]    nib;
  logic [6:0]    seg_d;
  assign wrap = slot_cnt == CW'(DIGIT_CYCLES - 1);
  assign nib  = 4'(snapshot >> {digit, 2'b00});
`ifdef DISP_LZ_BLANK_EN
  assign drive = state == S_DRIVE && !(digit == 2'd3 && snapshot[15:12] == 4'h0);
`else
  assign drive = state == S_DRIVE;
`endif
  always_comb begin
    seg_d = 7'h3F;
    case (nib)
      4'd0: seg_d = 7'h40;
      4'd1: seg_d = 7'h79;
      4'd2: seg_d = 7'h24;
      4'd3: seg_d = 7'h30;
      4'd4: seg_d = 7'h19;
      4'd5: seg_d = 7'h12;
      4'd6: seg_d = 7'h02;
      4'd7: seg_d = 7'h78;
      4'd8: seg_d = 7'h00;
      4'd9: seg_d = 7'h10;
      default: seg_d = 7'h3F;
    endcase
  end
  // State leads the pins by one cycle, so blank/drive widths on the pins match the slot counts exactly.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state    <= S_BLANK;
      slot_cnt <= '0;
      digit    <= 2'd0;
      snapshot <= 16'h0000;
      dp_phase <= 1'b0;
      an       <= 4'hF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
      if (wrap) digit <= digit + 2'd1;
      if (digit == 2'd0 && slot_cnt == '0) snapshot <= {min, sec};
      if (clk_flag) dp_phase <= ~dp_phase;
      case (state)
        S_BLANK: state <= slot_cnt == CW'(BLANK_CYCLES - 1) ? S_DRIVE : S_BLANK;
        S_DRIVE: state <= wrap ? S_BLANK : S_DRIVE;
        default: state <= S_BLANK;
      endcase
      an  <= drive ? ~(4'b0001 << digit) : 4'hF;
      seg <= drive ? seg_d : 7'h7F;
      dp  <= !(state == S_DRIVE && digit == 2'd2 && dp_phase);
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of seg_scan_driver against a cycle-position reference model.
module tb_seg_scan_driver;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FR = 4 * DC;
  logic       sys_clk = 0;
  logic       sys_rst_n = 0;
  logic [7:0] sec = 0;
  logic [7:0] min = 0;
  logic       clk_flag = 0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  int         n_cmp = 0;
  int         n_err = 0;
  int         p;
  logic [15:0] m_snap;
  bit         m_dp;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  seg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sec(sec), .min(min),
    .clk_flag(clk_flag), .an(an), .seg(seg), .dp(dp)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return n > 4'd9 ? 7'h3F : t[n];
  endfunction

  // Cycle p since reset release sits at digit (p/DC)%4, slot position p%DC; pins show that one edge later.
  task automatic tick();
    int d;
    int pos;
    bit drv;
    d = (p / DC) % 4;
    pos = p % DC;
    drv = pos >= BC;
`ifdef DISP_LZ_BLANK_EN
    if (d == 3 && m_snap[15:12] == 4'h0) drv = 0;
`endif
    e_an = drv ? ~(4'b0001 << d) : 4'hF;
    e_seg = drv ? dec(4'(m_snap >> (4 * d))) : 7'h7F;
    e_dp = !(pos >= BC && d == 2 && m_dp);
    if (p % FR == 0) m_snap = {min, sec};
    if (clk_flag) m_dp = !m_dp;
    @(posedge sys_clk);
    @(negedge sys_clk);
    clk_flag = 0;
    p++;
  endtask

  task automatic model_reset();
    p = 0;
    m_snap = 16'h0000;
    m_dp = 0;
  endtask

  task automatic align_frame();
    while (p % FR != 0) tick();
  endtask

  task automatic test_reset();
    sys_rst_n = 0;
    sec = 8'h00;
    min = 8'h00;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_err++;
      $display("FAIL reset_hold: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    sys_rst_n = 1;
    model_reset();
    repeat (3) begin
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL reset_release p=%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", p, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    n_cmp++;
    if ({an, seg} !== {4'b1110, 7'h40}) begin
      n_err++;
      $display("FAIL first_drive: got an=%b seg=%h want an=1110 seg=40", an, seg);
    end
  endtask

  task automatic test_frame();
    sec = 8'h59;
    min = 8'h12;
    align_frame();
    repeat (2 * FR) begin
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL frame_5912 p=%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", p, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (p % FR == 3 * DC + BC + 1) begin
        n_cmp++;
        if ({an, seg} !== {4'b0111, 7'h79}) begin
          n_err++;
          $display("FAIL min_tens_digit: got an=%b seg=%h want an=0111 seg=79", an, seg);
        end
      end
    end
  endtask

  task automatic test_midframe_change();
    sec = 8'h59;
    align_frame();
    while ((p / DC) % 4 != 1) tick();
    sec = 8'h00;
    repeat (2 * FR) begin
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL midframe p=%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", p, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_invalid();
    sec = 8'h3A;
    align_frame();
    repeat (FR) begin
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL invalid_nibble p=%0d: got an=%b seg=%h want an=%b seg=%h", p, an, seg, e_an, e_seg);
      end
    end
  endtask

  task automatic test_dp();
    int lows = 0;
    clk_flag = 1;
    repeat (3 * FR) begin
      tick();
      n_cmp++;
      if (dp === 1'b0) lows++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL dp_on p=%0d: got dp=%b an=%b want dp=%b an=%b", p, dp, an, e_dp, e_an);
      end
    end
    n_cmp++;
    if (lows < 3 * (DC - BC) - 1) begin
      n_err++;
      $display("FAIL dp_blink_count: got %0d low cycles want >= %0d", lows, 3 * (DC - BC) - 1);
    end
    clk_flag = 1;
    repeat (2 * FR) begin
      tick();
      n_cmp++;
      if (dp !== 1'b1 && p > 2) begin
        n_err++;
        $display("FAIL dp_off p=%0d: got dp=%b want 1", p, dp);
      end
    end
  endtask

  task automatic test_lz();
    min = 8'h05;
    sec = 8'h00;
    align_frame();
    repeat (2 * FR) begin
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL leading_zero p=%0d: got an=%b seg=%h want an=%b seg=%h", p, an, seg, e_an, e_seg);
      end
    end
  endtask

  task automatic test_random();
    repeat (16 * FR) begin
      if ($urandom_range(0, 19) == 0) sec = 8'($urandom);
      if ($urandom_range(0, 19) == 0) min = 8'($urandom);
      clk_flag = $urandom_range(0, 29) == 0;
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL random p=%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", p, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_async_reset();
    sec = 8'h47;
    min = 8'h23;
    align_frame();
    while (!((p / DC) % 4 == 2 && p % DC == 5)) tick();
    #2 sys_rst_n = 0;
    #1;
    n_cmp++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    @(negedge sys_clk);
    sys_rst_n = 1;
    model_reset();
    repeat (2 * FR) begin
      tick();
      n_cmp++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_err++;
        $display("FAIL restart p=%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", p, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_midframe_change();
    test_invalid();
    test_dp();
    test_lz();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
